// File: rtl/data_check_pkg.sv
// Shared definitions for the comma-framed PRBS receiver/checker.
package data_check_pkg;

  localparam int         WORD_W        = 10;
  localparam logic [9:0] COMMA_WORD    = 10'b1100_1100_11;
  localparam int         FRAME_CNT_W   = 16;
  localparam int         BIT_ERR_CNT_W = 32;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    TAIL    = 2'd2
  } state_t;

  // Number of set bits in one received word (0..10).
  function automatic logic [3:0] popcnt10(input logic [WORD_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/data_check_prbs_self_check.sv
// Self-synchronous PRBS checker: one 10-bit word per valid cycle, MSB first.
// Expected bits are derived from previously received bits, so a single
// flipped bit shows up at its own position and at both tap positions.
module data_check_prbs_self_check
  import data_check_pkg::*;
#(
  parameter int POLY_LENGHT = 9,
  parameter int POLY_TAP    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word,
  input  logic              word_vld,
  input  logic              seed,
  output logic [WORD_W-1:0] mismatch,
  output logic [3:0]        err_cnt
);

  localparam int SW = POLY_LENGHT + WORD_W;

  // hist[0] is the oldest bit; s[] is history followed by the word in stream order
  logic [POLY_LENGHT-1:0] hist, hist_nxt;
  logic [SW-1:0]          s;
  logic [WORD_W-1:0]      mis;

  // Bitwise check; in the seed word only bits with stream index >= POLY_LENGHT count
  always_comb begin
    s        = '0;
    mis      = '0;
    hist_nxt = '0;
    for (int i = 0; i < POLY_LENGHT; i++) s[i] = hist[i];
    for (int i = 0; i < WORD_W; i++) s[POLY_LENGHT+i] = word[WORD_W-1-i];
    for (int i = 0; i < WORD_W; i++) begin
      if (!seed || i >= POLY_LENGHT)
        mis[WORD_W-1-i] = s[POLY_LENGHT+i] ^ s[i] ^ s[POLY_LENGHT+i-POLY_TAP];
    end
    for (int i = 0; i < POLY_LENGHT; i++) hist_nxt[i] = s[WORD_W+i];
  end

  // Register history and per-word result; idle cycles report zero errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      mismatch <= '0;
      err_cnt  <= '0;
    end else begin
      if (word_vld) hist <= hist_nxt;
      mismatch <= word_vld ? mis : '0;
      err_cnt  <= word_vld ? popcnt10(mis) : 4'd0;
    end
  end

endmodule

// File: rtl/data_check.sv
// Frame receiver: hunts the head comma, checks PRBS_LENGTH payload words,
// verifies the tail comma and keeps saturating frame/bit-error statistics.
module data_check
  import data_check_pkg::*;
#(
  parameter int         PRBS_LENGTH = 8,
  parameter int         INV_PATTERN = 0,
  parameter int         POLY_LENGHT = 9,
  parameter int         POLY_TAP    = 5,
  parameter logic [9:0] COMMA       = COMMA_WORD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_W-1:0]        data_in,
  input  logic                     clear_cnt,
  output logic                     in_frame,
  output logic                     frame_ok,
  output logic                     frame_bad,
  output logic [FRAME_CNT_W-1:0]   frame_cnt,
  output logic [FRAME_CNT_W-1:0]   bad_frame_cnt,
  output logic [BIT_ERR_CNT_W-1:0] bit_err_cnt
);

  localparam int CW = (PRBS_LENGTH > 2) ? $clog2(PRBS_LENGTH) : 1;

  state_t            state;
  logic [CW-1:0]     word_idx;
  logic              frame_err;
  logic [WORD_W-1:0] rx_word;
  logic [WORD_W-1:0] chk_mismatch;
  logic [3:0]        chk_err_cnt;
  logic              ok_nxt, bad_nxt;
  logic [BIT_ERR_CNT_W:0] bit_sum;

  assign rx_word = (INV_PATTERN != 0) ? ~data_in : data_in;

  data_check_prbs_self_check #(
    .POLY_LENGHT(POLY_LENGHT),
    .POLY_TAP   (POLY_TAP)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .word    (rx_word),
    .word_vld(state == PAYLOAD),
    .seed    (word_idx == '0),
    .mismatch(chk_mismatch),
    .err_cnt (chk_err_cnt)
  );

  // Frame verdict at tail; the last payload word's errors arrive this same cycle
  always_comb begin
    bad_nxt = (state == TAIL) &&
              ((data_in != COMMA) || frame_err || (chk_err_cnt != 4'd0));
    ok_nxt  = (state == TAIL) && !bad_nxt;
  end

  // Framing FSM with registered in_frame and verdict pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      word_idx  <= '0;
      frame_err <= 1'b0;
      in_frame  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      frame_ok  <= ok_nxt;
      frame_bad <= bad_nxt;
      case (state)
        HUNT: begin
          if (data_in == COMMA) begin
            state     <= PAYLOAD;
            word_idx  <= '0;
            frame_err <= 1'b0;
            in_frame  <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (chk_err_cnt != 4'd0) frame_err <= 1'b1;
          if (word_idx == CW'(PRBS_LENGTH-1)) begin
            state    <= TAIL;
            word_idx <= '0;
          end else begin
            word_idx <= word_idx + 1'b1;
          end
        end
        TAIL: begin
          state    <= HUNT;
          in_frame <= 1'b0;
        end
        default: begin
          state    <= HUNT;
          in_frame <= 1'b0;
        end
      endcase
    end
  end

  assign bit_sum = {1'b0, bit_err_cnt} + (BIT_ERR_CNT_W+1)'(chk_err_cnt);

  // Saturating statistics; clear wins over any same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt     <= '0;
      bad_frame_cnt <= '0;
      bit_err_cnt   <= '0;
    end else if (clear_cnt) begin
      frame_cnt     <= '0;
      bad_frame_cnt <= '0;
      bit_err_cnt   <= '0;
    end else begin
      if ((ok_nxt || bad_nxt) && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      if (bad_nxt && bad_frame_cnt != '1) bad_frame_cnt <= bad_frame_cnt + 1'b1;
      bit_err_cnt <= bit_sum[BIT_ERR_CNT_W] ? '1 : bit_sum[BIT_ERR_CNT_W-1:0];
    end
  end

endmodule
